// File: rtl/univ_shift_burst_reg.sv
// Parametrised universal shift register with an autonomous burst engine.
// Optional registered parity output `par` is built when PARITY_OUT_EN is defined.
module univ_shift_burst_reg #(
    parameter int N     = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       s,
    input  logic             msb,
    input  logic             lsb,
    input  logic [N-1:0]     I,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [N-1:0]     q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
`ifdef PARITY_OUT_EN
    ,
    output logic             par
`endif
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       q_q, q_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) ||
               (op == 3'b101) || (op == 3'b110);
    endfunction

    function automatic logic [N-1:0] apply_op(
        input logic [2:0]   op,
        input logic [N-1:0] cur,
        input logic [N-1:0] ld,
        input logic         si_l,
        input logic         si_r
    );
        logic [N-1:0] nxt;
        case (op)
            3'b001:  nxt = {si_l, cur[N-1:1]};
            3'b010:  nxt = {cur[N-2:0], si_r};
            3'b011:  nxt = ld;
            3'b100:  nxt = {cur[0], cur[N-1:1]};
            3'b101:  nxt = {cur[N-2:0], cur[N-1]};
            3'b110:  nxt = {cur[N-1], cur[N-1:1]};
            3'b111:  nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && is_shift(s)) begin
                    // Accepting a burst never moves q; amt=0 just reports completion.
                    if (amt != '0) begin
                        mode_d  = s;
                        cnt_d   = amt;
                        state_d = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    q_d = apply_op(s, q_q, I, msb, lsb);
                end
            end
            BURST: begin
                if (en) begin
                    q_d   = apply_op(mode_q, q_q, I, msb, lsb);
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == BURST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign so_r = q_q[0];
    assign so_l = q_q[N-1];
    assign busy = busy_q;
    assign done = done_q;

`ifdef PARITY_OUT_EN
    logic par_q, par_d;

    assign par_d = ^q_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par = par_q;
`endif

endmodule

// File: tb/tb_univ_shift_burst_reg.sv
// Directed testbench for univ_shift_burst_reg (N=8, AMT_W=4).
// Checks par as well when PARITY_OUT_EN is defined.
module tb_univ_shift_burst_reg;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [2:0] s;
    logic       msb;
    logic       lsb;
    logic [7:0] I;
    logic       start;
    logic [3:0] amt;
    logic [7:0] q;
    logic       so_r;
    logic       so_l;
    logic       busy;
    logic       done;
`ifdef PARITY_OUT_EN
    logic       par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_burst_reg #(.N(8), .AMT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .s       (s),
        .msb     (msb),
        .lsb     (lsb),
        .I       (I),
        .start   (start),
        .amt     (amt),
        .q       (q),
        .so_r    (so_r),
        .so_l    (so_l),
        .busy    (busy),
        .done    (done)
`ifdef PARITY_OUT_EN
        ,
        .par     (par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; s = 3'b000; msb = 1'b0; lsb = 1'b0;
        I = 8'h00; start = 1'b0; amt = 4'd0;
        tick();
        reset_n = 1'b1;
        s = 3'b011; I = 8'hA5; en = 1'b1;
        tick();
        s = 3'b000;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_pre_edge: q=%h expected=%h", q, 8'hA5); end
        tick();
        n_checks++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: q=%h expected=%h", q, 8'h00); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy=%b expected=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: done=%b expected=0", done); end
`ifdef PARITY_OUT_EN
        n_checks++;
        if (par !== 1'b0) begin n_fail++; $display("FAIL reset_par: par=%b expected=0", par); end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_basic_ops();
        en = 1'b1; s = 3'b011; I = 8'hB4;
        tick();
        n_checks++;
        if (q !== 8'hB4) begin n_fail++; $display("FAIL load: q=%h expected=%h", q, 8'hB4); end
        s = 3'b001; msb = 1'b1;
        tick();
        n_checks++;
        if (q !== 8'hDA) begin n_fail++; $display("FAIL shift_right: q=%h expected=%h", q, 8'hDA); end
        s = 3'b010; lsb = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'hB4) begin n_fail++; $display("FAIL shift_left: q=%h expected=%h", q, 8'hB4); end
        en = 1'b0; s = 3'b011; I = 8'h00;
        tick();
        n_checks++;
        if (q !== 8'hB4) begin n_fail++; $display("FAIL en_low_hold: q=%h expected=%h", q, 8'hB4); end
        en = 1'b1; s = 3'b000;
        tick();
        n_checks++;
        if (q !== 8'hB4) begin n_fail++; $display("FAIL hold_mode: q=%h expected=%h", q, 8'hB4); end
    endtask

    task automatic test_rotate_arith_clear();
        logic [7:0] ld_v [4]  = '{8'h81, 8'h81, 8'h90, 8'h90};
        logic [2:0] md_v [4]  = '{3'b100, 3'b101, 3'b110, 3'b111};
        logic [7:0] exp_v [4] = '{8'hC0, 8'h03, 8'hC8, 8'h00};
        logic [7:0] e;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = 3'b011; I = ld_v[i];
            tick();
            e = ld_v[i];
            n_checks++;
            if (so_r !== e[0] || so_l !== e[7]) begin
                n_fail++; $display("FAIL so_taps_load%0d: so_r=%b so_l=%b expected=%b %b", i, so_r, so_l, e[0], e[7]);
            end
            s = md_v[i];
            tick();
            e = exp_v[i];
            n_checks++;
            if (q !== e) begin n_fail++; $display("FAIL mode%0d_q: q=%h expected=%h", i, q, e); end
            n_checks++;
            if (so_r !== e[0] || so_l !== e[7]) begin
                n_fail++; $display("FAIL so_taps_mode%0d: so_r=%b so_l=%b expected=%b %b", i, so_r, so_l, e[0], e[7]);
            end
`ifdef PARITY_OUT_EN
            n_checks++;
            if (par !== ^e) begin n_fail++; $display("FAIL par_mode%0d: par=%b expected=%b", i, par, ^e); end
`endif
        end
        s = 3'b000;
    endtask

    task automatic test_burst_rotate();
        logic [7:0] exp_v [3] = '{8'h02, 8'h04, 8'h08};
        en = 1'b1; s = 3'b011; I = 8'h01;
        tick();
        start = 1'b1; s = 3'b101; amt = 4'd3;
        tick();
        start = 1'b0; s = 3'b000;
        n_checks++;
        if (q !== 8'h01 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL burst_accept: q=%h busy=%b done=%b expected=01 1 0", q, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== exp_v[i]) begin n_fail++; $display("FAIL burst_rl_step%0d: q=%h expected=%h", i, q, exp_v[i]); end
            n_checks++;
            if (busy !== (i != 2) || done !== (i == 2)) begin
                n_fail++; $display("FAIL burst_rl_status%0d: busy=%b done=%b expected=%b %b", i, busy, done, i != 2, i == 2);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h08) begin
            n_fail++; $display("FAIL burst_rl_after: q=%h busy=%b done=%b expected=08 0 0", q, busy, done);
        end
    endtask

    task automatic test_burst_stall_and_abort();
        logic [7:0] exp_v [6] = '{8'h80, 8'h80, 8'h80, 8'hC0, 8'hE0, 8'hF0};
        logic       en_v  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        en = 1'b1; s = 3'b111;
        tick();
        start = 1'b1; s = 3'b001; amt = 4'd4; msb = 1'b1;
        tick();
        start = 1'b0; s = 3'b000;
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b1) begin
            n_fail++; $display("FAIL stall_accept: q=%h busy=%b expected=00 1", q, busy);
        end
        for (int i = 0; i < 6; i++) begin
            en = en_v[i];
            tick();
            n_checks++;
            if (q !== exp_v[i]) begin n_fail++; $display("FAIL stall_step%0d: q=%h expected=%h", i, q, exp_v[i]); end
            n_checks++;
            if (done !== (i == 5) || busy !== (i != 5)) begin
                n_fail++; $display("FAIL stall_status%0d: busy=%b done=%b expected=%b %b", i, busy, done, i != 5, i == 5);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done_pulse: done=%b expected=0", done); end

        s = 3'b111;
        tick();
        start = 1'b1; s = 3'b001; amt = 4'd4;
        tick();
        start = 1'b0; s = 3'b000;
        tick();
        tick();
        n_checks++;
        if (q !== 8'hC0) begin n_fail++; $display("FAIL abort_pre: q=%h expected=%h", q, 8'hC0); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_reset: q=%h busy=%b done=%b expected=00 0 0", q, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin
                n_fail++; $display("FAIL abort_quiet%0d: q=%h busy=%b done=%b expected=00 0 0", i, q, busy, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; s = 3'b011; I = 8'h5A;
        tick();
        start = 1'b1; s = 3'b001; amt = 4'd0;
        tick();
        start = 1'b0; s = 3'b000;
        n_checks++;
        if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL amt0: q=%h busy=%b done=%b expected=5a 0 1", q, busy, done);
        end
        tick();
        n_checks++;
        if (q !== 8'h5A || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL amt0_after: q=%h busy=%b done=%b expected=5a 0 0", q, busy, done);
        end

        start = 1'b1; s = 3'b100; amt = 4'd2;
        tick();
        // Noise on start/s/I/amt while the burst runs must be ignored.
        start = 1'b1; s = 3'b011; I = 8'h00; amt = 4'd5;
        tick();
        n_checks++;
        if (q !== 8'h2D || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL ignore_step1: q=%h busy=%b done=%b expected=2d 1 0", q, busy, done);
        end
        tick();
        n_checks++;
        if (q !== 8'h96 || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL ignore_done: q=%h busy=%b done=%b expected=96 0 1", q, busy, done);
        end
        start = 1'b1; s = 3'b101; amt = 4'd1;
        tick();
        start = 1'b0; s = 3'b000;
        n_checks++;
        if (q !== 8'h96 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: q=%h busy=%b done=%b expected=96 1 0", q, busy, done);
        end
        tick();
        n_checks++;
        if (q !== 8'h2D || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done: q=%h busy=%b done=%b expected=2d 0 1", q, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_rotate_arith_clear();
        test_burst_rotate();
        test_burst_stall_and_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
